// File: rtl/write_back_stage.sv
// Final pipeline stage: commits execute results to the register file, flags and memory.
// Multi-cycle commits (upper-word writes, stores awaiting mem_ready) stall upstream via in_hold.
module write_back_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_BITS   = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_hold,
    input  logic [DATA_WIDTH-1:0] in_pc,
    input  logic [REG_BITS-1:0]   in_destination_register,
    input  logic                  in_is_writing_memory,
    input  logic [3:0]            in_flags,
    input  logic [DATA_WIDTH-1:0] in_destination_value,
    input  logic                  in_has_upper_value,
    input  logic [DATA_WIDTH-1:0] in_upper_value,
    input  logic [DATA_WIDTH-1:0] in_adjustment_value,
    input  logic                  in_has_flushed,
    output logic [REG_BITS-1:0]   reg_read_index,
    input  logic [DATA_WIDTH-1:0] reg_read_value,
    output logic                  reg_write_enable,
    output logic [REG_BITS-1:0]   reg_write_index,
    output logic [DATA_WIDTH-1:0] reg_write_value,
    output logic                  flags_write_enable,
    output logic [3:0]            flags_value,
    output logic                  mem_request,
    output logic [DATA_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic                  mem_ready,
    output logic                  retire_valid,
    output logic [DATA_WIDTH-1:0] retire_pc
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        UPPER    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic                  reg_we_q, reg_we_d;
    logic [REG_BITS-1:0]   reg_idx_q, reg_idx_d;
    logic [DATA_WIDTH-1:0] reg_val_q, reg_val_d;
    logic                  flags_we_q, flags_we_d;
    logic [3:0]            flags_val_q, flags_val_d;
    logic                  mem_req_q, mem_req_d;
    logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                  retire_q, retire_d;
    logic [DATA_WIDTH-1:0] retire_pc_q, retire_pc_d;
    logic [DATA_WIDTH-1:0] pend_pc_q, pend_pc_d;
    logic [REG_BITS-1:0]   up_idx_q, up_idx_d;
    logic [DATA_WIDTH-1:0] up_val_q, up_val_d;

    assign in_hold            = (state_q != IDLE);
    assign reg_read_index     = in_destination_register;
    assign reg_write_enable   = reg_we_q;
    assign reg_write_index    = reg_idx_q;
    assign reg_write_value    = reg_val_q;
    assign flags_write_enable = flags_we_q;
    assign flags_value        = flags_val_q;
    assign mem_request        = mem_req_q;
    assign mem_address        = mem_addr_q;
    assign mem_write_data     = mem_data_q;
    assign retire_valid       = retire_q;
    assign retire_pc          = retire_pc_q;

    // Next-state and registered-output computation; strobes default low, data holds.
    always_comb begin
        state_d     = state_q;
        reg_we_d    = 1'b0;
        reg_idx_d   = reg_idx_q;
        reg_val_d   = reg_val_q;
        flags_we_d  = 1'b0;
        flags_val_d = flags_val_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_data_d  = mem_data_q;
        retire_d    = 1'b0;
        retire_pc_d = retire_pc_q;
        pend_pc_d   = pend_pc_q;
        up_idx_d    = up_idx_q;
        up_val_d    = up_val_q;
        case (state_q)
            IDLE: begin
                if (in_valid && !in_has_flushed) begin
                    if (in_is_writing_memory) begin
                        mem_req_d  = 1'b1;
                        mem_addr_d = reg_read_value + in_adjustment_value;
                        mem_data_d = in_destination_value;
                        pend_pc_d  = in_pc;
                        state_d    = MEM_WAIT;
                    end else begin
                        reg_we_d    = (in_destination_register != {REG_BITS{1'b0}});
                        reg_idx_d   = in_destination_register;
                        reg_val_d   = in_destination_value;
                        flags_we_d  = 1'b1;
                        flags_val_d = in_flags;
                        if (in_has_upper_value) begin
                            // Index wraps modulo 2^REG_BITS, so dest 31 lands on the discard register.
                            up_idx_d  = in_destination_register + {{(REG_BITS-1){1'b0}}, 1'b1};
                            up_val_d  = in_upper_value;
                            pend_pc_d = in_pc;
                            state_d   = UPPER;
                        end else begin
                            retire_d    = 1'b1;
                            retire_pc_d = in_pc;
                        end
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            UPPER: begin
                reg_we_d    = (up_idx_q != {REG_BITS{1'b0}});
                reg_idx_d   = up_idx_q;
                reg_val_d   = up_val_q;
                retire_d    = 1'b1;
                retire_pc_d = pend_pc_q;
                state_d     = IDLE;
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    mem_req_d   = 1'b0;
                    retire_d    = 1'b1;
                    retire_pc_d = pend_pc_q;
                    state_d     = IDLE;
                end else begin
                    state_d = MEM_WAIT;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            reg_we_q    <= 1'b0;
            reg_idx_q   <= {REG_BITS{1'b0}};
            reg_val_q   <= {DATA_WIDTH{1'b0}};
            flags_we_q  <= 1'b0;
            flags_val_q <= 4'd0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= {DATA_WIDTH{1'b0}};
            mem_data_q  <= {DATA_WIDTH{1'b0}};
            retire_q    <= 1'b0;
            retire_pc_q <= {DATA_WIDTH{1'b0}};
            pend_pc_q   <= {DATA_WIDTH{1'b0}};
            up_idx_q    <= {REG_BITS{1'b0}};
            up_val_q    <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            reg_we_q    <= reg_we_d;
            reg_idx_q   <= reg_idx_d;
            reg_val_q   <= reg_val_d;
            flags_we_q  <= flags_we_d;
            flags_val_q <= flags_val_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            retire_q    <= retire_d;
            retire_pc_q <= retire_pc_d;
            pend_pc_q   <= pend_pc_d;
            up_idx_q    <= up_idx_d;
            up_val_q    <= up_val_d;
        end
    end

endmodule

// File: tb/tb_write_back_stage.sv
// Bench for write_back_stage: directed scenarios then random instructions, each
// checked cycle by cycle against expectations derived from the commit rules.
module tb_write_back_stage;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_hold;
    logic [31:0] in_pc;
    logic [4:0]  in_destination_register;
    logic        in_is_writing_memory;
    logic [3:0]  in_flags;
    logic [31:0] in_destination_value;
    logic        in_has_upper_value;
    logic [31:0] in_upper_value;
    logic [31:0] in_adjustment_value;
    logic        in_has_flushed;
    logic [4:0]  reg_read_index;
    logic [31:0] reg_read_value;
    logic        reg_write_enable;
    logic [4:0]  reg_write_index;
    logic [31:0] reg_write_value;
    logic        flags_write_enable;
    logic [3:0]  flags_value;
    logic        mem_request;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_ready;
    logic        retire_valid;
    logic [31:0] retire_pc;

    logic [31:0] regs [32];
    int n_pass  = 0;
    int n_total = 0;

    assign reg_read_value = regs[reg_read_index];

    write_back_stage dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_hold(in_hold),
        .in_pc(in_pc), .in_destination_register(in_destination_register),
        .in_is_writing_memory(in_is_writing_memory), .in_flags(in_flags),
        .in_destination_value(in_destination_value), .in_has_upper_value(in_has_upper_value),
        .in_upper_value(in_upper_value), .in_adjustment_value(in_adjustment_value),
        .in_has_flushed(in_has_flushed), .reg_read_index(reg_read_index),
        .reg_read_value(reg_read_value), .reg_write_enable(reg_write_enable),
        .reg_write_index(reg_write_index), .reg_write_value(reg_write_value),
        .flags_write_enable(flags_write_enable), .flags_value(flags_value),
        .mem_request(mem_request), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_ready(mem_ready),
        .retire_valid(retire_valid), .retire_pc(retire_pc)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic expect_cycle(input string tag, input logic e_hold, input logic e_rwe,
                                input logic [4:0] e_ridx, input logic [31:0] e_rval,
                                input logic e_fwe, input logic [3:0] e_fval, input logic e_mreq,
                                input logic [31:0] e_maddr, input logic [31:0] e_mdata,
                                input logic e_ret, input logic [31:0] e_rpc);
        chk({tag, ".hold"}, 32'(in_hold), 32'(e_hold));
        chk({tag, ".rwe"}, 32'(reg_write_enable), 32'(e_rwe));
        chk({tag, ".fwe"}, 32'(flags_write_enable), 32'(e_fwe));
        chk({tag, ".mreq"}, 32'(mem_request), 32'(e_mreq));
        chk({tag, ".ret"}, 32'(retire_valid), 32'(e_ret));
        if (e_rwe) begin
            chk({tag, ".ridx"}, 32'(reg_write_index), 32'(e_ridx));
            chk({tag, ".rval"}, reg_write_value, e_rval);
        end
        if (e_fwe) chk({tag, ".fval"}, 32'(flags_value), 32'(e_fval));
        if (e_mreq) begin
            chk({tag, ".maddr"}, mem_address, e_maddr);
            chk({tag, ".mdata"}, mem_write_data, e_mdata);
        end
        if (e_ret) chk({tag, ".rpc"}, retire_pc, e_rpc);
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input string tag, input logic rdy);
        in_valid  = 1'b0;
        mem_ready = rdy;
        step();
        expect_cycle(tag, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        mem_ready = 1'b0;
    endtask

    // Issues one instruction and checks every cycle until the stage is ready again.
    task automatic do_instr(input string tag, input logic [31:0] pc, input logic [4:0] dest,
                            input logic st, input logic [3:0] fl, input logic [31:0] val,
                            input logic hu, input logic [31:0] up, input logic [31:0] adj,
                            input logic fls, input int delay);
        logic [31:0] addr;
        int ui;
        in_valid = 1'b1; in_pc = pc; in_destination_register = dest;
        in_is_writing_memory = st; in_flags = fl; in_destination_value = val;
        in_has_upper_value = hu; in_upper_value = up; in_adjustment_value = adj;
        in_has_flushed = fls;
        #1 chk({tag, ".rdidx"}, 32'(reg_read_index), 32'(dest));
        step();
        if (fls) begin
            expect_cycle({tag, ".n1"}, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0,
                         1'b0, 32'd0);
        end else if (st) begin
            addr = regs[dest] + adj;
            expect_cycle({tag, ".n1"}, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 4'd0, 1'b1, addr, val,
                         1'b0, 32'd0);
            for (int i = 0; i < delay; i++) begin
                step();
                expect_cycle({tag, ".wait"}, 1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 4'd0, 1'b1, addr, val,
                             1'b0, 32'd0);
            end
            mem_ready = 1'b1;
            step();
            mem_ready = 1'b0;
            expect_cycle({tag, ".done"}, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0,
                         1'b1, pc);
        end else begin
            expect_cycle({tag, ".n1"}, hu, (dest != 5'd0), dest, val, 1'b1, fl, 1'b0, 32'd0,
                         32'd0, !hu, pc);
            if (hu) begin
                ui = (int'(dest) + 1) % 32;
                step();
                expect_cycle({tag, ".n2"}, 1'b0, (ui != 0), 5'(ui), up, 1'b0, 4'd0, 1'b0, 32'd0,
                             32'd0, 1'b1, pc);
            end
        end
    endtask

    initial begin
        int kind;
        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[2] = 32'h0000_0100;
        reset = 1'b1; in_valid = 1'b0; in_pc = 32'd0; in_destination_register = 5'd0;
        in_is_writing_memory = 1'b0; in_flags = 4'd0; in_destination_value = 32'd0;
        in_has_upper_value = 1'b0; in_upper_value = 32'd0; in_adjustment_value = 32'd0;
        in_has_flushed = 1'b0; mem_ready = 1'b0;
        repeat (2) step();
        expect_cycle("reset", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
        chk("reset.ridx", 32'(reg_write_index), 32'd0);
        chk("reset.rval", reg_write_value, 32'd0);
        chk("reset.fval", 32'(flags_value), 32'd0);
        chk("reset.maddr", mem_address, 32'd0);
        chk("reset.rpc", retire_pc, 32'd0);
        reset = 1'b0;
        idle("idle0", 1'b0);

        do_instr("add", 32'h0000_1000, 5'd3, 1'b0, 4'b0001, 32'h0000_0005, 1'b0, 32'd0, 32'd0,
                 1'b0, 0);
        do_instr("mul", 32'h0000_1004, 5'd7, 1'b0, 4'b0100, 32'hDEAD_BEEF, 1'b1, 32'h1, 32'd0,
                 1'b0, 0);
        do_instr("wrap", 32'h0000_1008, 5'd31, 1'b0, 4'b1000, 32'h1234_5678, 1'b1, 32'h9, 32'd0,
                 1'b0, 0);
        do_instr("store", 32'h0000_100C, 5'd2, 1'b1, 4'b1111, 32'h0000_0055, 1'b0, 32'd0, 32'h8,
                 1'b0, 3);
        do_instr("flush", 32'h0000_1010, 5'd4, 1'b0, 4'b0011, 32'h0000_0077, 1'b0, 32'd0, 32'd0,
                 1'b1, 0);
        do_instr("r0", 32'h0000_1014, 5'd0, 1'b0, 4'b0110, 32'h0000_0099, 1'b0, 32'd0, 32'd0,
                 1'b0, 0);
        do_instr("b2b", 32'h0000_1018, 5'd9, 1'b0, 4'b0010, 32'h0000_00AA, 1'b0, 32'd0, 32'd0,
                 1'b0, 0);
        idle("stray_ready", 1'b1);

        // Reset while a store waits for mem_ready: the store must be abandoned.
        in_valid = 1'b1; in_pc = 32'h0000_2000; in_destination_register = 5'd2;
        in_is_writing_memory = 1'b1; in_has_flushed = 1'b0; in_adjustment_value = 32'h4;
        in_destination_value = 32'hCAFE_0001;
        step();
        chk("rstmid.mreq_before", 32'(mem_request), 32'd1);
        reset = 1'b1;
        step();
        expect_cycle("rstmid", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 4'd0, 1'b0, 32'd0, 32'd0, 1'b0,
                     32'd0);
        chk("rstmid.maddr", mem_address, 32'd0);
        reset = 1'b0;
        idle("rstmid.after", 1'b1);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 9);
            do_instr("rand", $urandom, 5'($urandom), (kind >= 1 && kind <= 3), 4'($urandom),
                     $urandom, (kind >= 4 && kind <= 5), $urandom, $urandom, (kind == 0),
                     $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) idle("rand.idle", 1'($urandom));
        end
        idle("final", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
